// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and opcode map for the multi-cycle sequencer.
// Imported by the classifier, the top and any hazard logic.
package multicycle_sequencer_pkg;

   localparam int unsigned OP_NOP     = 0;
   localparam int unsigned OP_ALU_LO  = 1;
   localparam int unsigned OP_ALU_HI  = 12;
   localparam int unsigned OP_LOAD    = 13;
   localparam int unsigned OP_STORE   = 14;
   localparam int unsigned OP_BR_LO   = 15;
   localparam int unsigned OP_BR_HI   = 20;
   localparam int unsigned OP_JMP_LO  = 21;
   localparam int unsigned OP_JMP_HI  = 23;
   localparam int unsigned OP_ALU2_LO = 24;
   localparam int unsigned OP_ALU2_HI = 25;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JUMP,
      CLS_NOP,
      CLS_HALT,
      CLS_ILLEGAL
   } cls_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT,
      S_ERR
   } state_t;

   typedef enum logic [1:0] {
      PC_INC = 2'b00,
      PC_BR  = 2'b01,
      PC_JMP = 2'b10
   } pc_src_t;

   function automatic logic in_range(
      input int unsigned v,
      input int unsigned lo,
      input int unsigned hi
   );
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction/data memory request-ready handshake bundle.
// master = sequencer side, slave = memory side.
interface multicycle_sequencer_if;

   logic imem_req;
   logic imem_ready;
   logic dmem_req;
   logic dmem_we;
   logic dmem_ready;

   modport master (
      output imem_req,
      output dmem_req,
      output dmem_we,
      input  imem_ready,
      input  dmem_ready
   );

   modport slave (
      input  imem_req,
      input  dmem_req,
      input  dmem_we,
      output imem_ready,
      output dmem_ready
   );

endinterface

// File: rtl/multicycle_sequencer_opcode_classifier.sv
// Combinational opcode -> instruction class decoder.
// HALT_OP is checked first so it may alias any other encoding.
module multicycle_sequencer_opcode_classifier
   import multicycle_sequencer_pkg::*;
#(
   parameter int          OPW     = 6,
   parameter int unsigned HALT_OP = 63
) (
   input  logic [OPW-1:0] opcode,
   output cls_t           cls
);

   int unsigned op;

   always_comb begin
      op  = 32'(opcode);
      cls = CLS_ILLEGAL;
      if (op == HALT_OP)
         cls = CLS_HALT;
      else if (op == OP_NOP)
         cls = CLS_NOP;
      else if (op == OP_LOAD)
         cls = CLS_LOAD;
      else if (op == OP_STORE)
         cls = CLS_STORE;
      else if (in_range(op, OP_BR_LO, OP_BR_HI))
         cls = CLS_BRANCH;
      else if (in_range(op, OP_JMP_LO, OP_JMP_HI))
         cls = CLS_JUMP;
      else if (in_range(op, OP_ALU_LO, OP_ALU_HI))
         cls = CLS_ALU;
      else if (in_range(op, OP_ALU2_LO, OP_ALU2_HI))
         cls = CLS_ALU;
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with
// memory-wait timeout trap and retired-instruction counter.
module multicycle_sequencer
   import multicycle_sequencer_pkg::*;
#(
   parameter int          OPW     = 6,
   parameter int          CNT_W   = 32,
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned HALT_OP = 63
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [OPW-1:0]       opcode,
   input  logic                 branch_taken,
   multicycle_sequencer_if.master mem,
   output logic                 ir_load,
   output logic                 pc_write,
   output logic [1:0]           pc_src,
   output logic                 reg_write,
   output logic                 busy,
   output logic                 halted,
   output logic                 error,
   output logic [CNT_W-1:0]     retired_cnt
);

   localparam int WW = $clog2(TIMEOUT + 1);

   state_t        st;
   state_t        nxt;
   cls_t          cls_q;
   cls_t          dec_cls;
   logic [WW-1:0] wait_cnt;
   logic [WW-1:0] wait_d;
   logic          timed_out;
   logic          retire;
   logic          imem_req;
   logic          dmem_req;
   logic          dmem_we;
   pc_src_t       pc_sel;

   multicycle_sequencer_opcode_classifier #(
      .OPW     (OPW),
      .HALT_OP (HALT_OP)
   ) u_cls (
      .opcode (opcode),
      .cls    (dec_cls)
   );

   assign timed_out = (wait_cnt == WW'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st          <= S_IDLE;
         cls_q       <= CLS_NOP;
         wait_cnt    <= '0;
         retired_cnt <= '0;
      end else begin
         st       <= nxt;
         wait_cnt <= wait_d;
         if (st == S_DECODE)
            cls_q <= dec_cls;
         if (retire)
            retired_cnt <= retired_cnt + 1'b1;
      end
   end

   // wait_d defaults to 0, so any entry into FETCH/MEM
   // starts the wait counter from zero.
   always_comb begin
      nxt       = st;
      wait_d    = '0;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_load   = 1'b0;
      pc_write  = 1'b0;
      pc_sel    = PC_INC;
      reg_write = 1'b0;
      retire    = 1'b0;
      unique case (st)
         S_IDLE: begin
            if (start)
               nxt = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (mem.imem_ready) begin
               ir_load = 1'b1;
               nxt     = S_DECODE;
            end else if (timed_out) begin
               nxt = S_ERR;
            end else begin
               wait_d = wait_cnt + 1'b1;
            end
         end
         S_DECODE: begin
            case (dec_cls)
               CLS_NOP: begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
                  nxt      = S_FETCH;
               end
               CLS_HALT:    nxt = S_HALT;
               CLS_ILLEGAL: nxt = S_ERR;
               default:     nxt = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (cls_q)
               CLS_ALU: nxt = S_WB;
               CLS_LOAD,
               CLS_STORE: nxt = S_MEM;
               CLS_BRANCH: begin
                  pc_write = 1'b1;
                  pc_sel   = branch_taken ? PC_BR : PC_INC;
                  retire   = 1'b1;
                  nxt      = S_FETCH;
               end
               CLS_JUMP: begin
                  pc_write = 1'b1;
                  pc_sel   = PC_JMP;
                  retire   = 1'b1;
                  nxt      = S_FETCH;
               end
               default: nxt = S_ERR;
            endcase
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (cls_q == CLS_STORE);
            if (mem.dmem_ready) begin
               if (cls_q == CLS_STORE) begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
                  nxt      = S_FETCH;
               end else begin
                  nxt = S_WB;
               end
            end else if (timed_out) begin
               nxt = S_ERR;
            end else begin
               wait_d = wait_cnt + 1'b1;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            retire    = 1'b1;
            nxt       = S_FETCH;
         end
         S_HALT: nxt = S_HALT;
         S_ERR:  nxt = S_ERR;
      endcase
   end

   assign mem.imem_req = imem_req;
   assign mem.dmem_req = dmem_req;
   assign mem.dmem_we  = dmem_we;
   assign pc_src       = pc_sel;

   assign busy   = (st == S_FETCH) || (st == S_DECODE) ||
                   (st == S_EXEC)  || (st == S_MEM)    ||
                   (st == S_WB);
   assign halted = (st == S_HALT);
   assign error  = (st == S_ERR);

   ap_we_req: assert property (
      @(posedge clk) disable iff (!rst_n)
      dmem_we |-> dmem_req
   );

   ap_wb_pc: assert property (
      @(posedge clk) disable iff (!rst_n)
      reg_write |-> pc_write
   );

endmodule
